vc_skid_reg_bank: RTL

// - Bank of NUM_VC independent elastic pipeline registers, one per virtual channel, with a valid/ready handshake.
// - Each lane is a 2-entry skid buffer: full throughput, registered in_ready, per-lane synchronous flush.
// - Sits between input VC buffers and the switch-allocation stage; cuts the timing path on both data and ready.

---
 rtl/vc_skid_reg_bank.sv | 87 ++++++++
 1 files changed

// File: rtl/vc_skid_reg_bank.sv
// Purpose : bank of NUM_VC independent 2-entry skid registers (main + skid) with valid/ready.
// Latency : 1 cycle from push edge to out_valid/out_data; 1 flit/cycle/lane sustained.
// Backpressure: in_ready is registered (state != FULL); the skid entry absorbs the flit in flight.
module vc_skid_reg_bank #(
  parameter int DATA_W = 16,
  parameter int NUM_VC = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [NUM_VC-1:0]        flush,
  input  logic [NUM_VC-1:0]        in_valid,
  output logic [NUM_VC-1:0]        in_ready,
  input  logic [NUM_VC*DATA_W-1:0] in_data,
  output logic [NUM_VC-1:0]        out_valid,
  input  logic [NUM_VC-1:0]        out_ready,
  output logic [NUM_VC*DATA_W-1:0] out_data,
  output logic [NUM_VC*2-1:0]      occ
);

  // Encoding doubles as the occupancy count, so occ is a direct copy of state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

  genvar v;
  generate
    for (v = 0; v < NUM_VC; v++) begin : g_lane
      lane_state_t       state;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] skid_q;
      logic [DATA_W-1:0] lane_din;
      logic              push;
      logic              pop;

      assign lane_din = in_data[v*DATA_W +: DATA_W];
      assign push     = in_valid[v] & in_ready[v];
      assign pop      = out_valid[v] & out_ready[v];

      // Lane state machine: flush empties the lane but leaves the data registers alone,
      // so out_data keeps showing the last head flit.
      always_ff @(posedge clk) begin
        if (!clr_n) begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end else if (flush[v]) begin
          state <= EMPTY;
        end else begin
          case (state)
            EMPTY: begin
              if (push) begin
                state  <= ONE;
                main_q <= lane_din;
              end
            end
            ONE: begin
              if (push && pop) begin
                main_q <= lane_din;
              end else if (push) begin
                state  <= FULL;
                skid_q <= lane_din;
              end else if (pop) begin
                state <= EMPTY;
              end
            end
            FULL: begin
              // in_ready is low here, so only a pop can move the lane.
              if (pop) begin
                state  <= ONE;
                main_q <= skid_q;
              end
            end
            default: state <= EMPTY;
          endcase
        end
      end

      assign out_valid[v]                 = (state != EMPTY);
      assign in_ready[v]                  = (state != FULL);
      assign occ[2*v +: 2]                = state;
      assign out_data[v*DATA_W +: DATA_W] = main_q;
    end
  endgenerate

endmodule
